pong_game_ctrl: RTL

Game-sequencing controller that owns ball position, ball direction and scores, and drives the renderer's ball_x/ball_y inputs. It advances the game once every FRAMES_PER_STEP video frames, using the renderer's vsync as the frame tick. Each step it bounces the ball off the top and bottom walls and tests it against the left and right paddle bitmaps supplied by the paddle blocks. It detects misses, updates scores and sequences serve, play and game-over phases.

---
 rtl/pong_pkg.sv | 9 +
 rtl/pong_if.sv | 18 +
 rtl/pong_frame_tick.sv | 23 ++
 rtl/pong_game_ctrl.sv | 132 +++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: shared game state encoding, board constants and direction encoding.
package pong_pkg;
    typedef enum logic [1:0] {SERVE, PLAY, MISS, GAMEOVER} state_t;
    localparam logic [4:0] CENTER = 5'd15;
    localparam logic [4:0] LCOL = 5'd31;
    localparam logic [4:0] RCOL = 5'd0;
    localparam logic DIR_POS = 1'b1;
    localparam logic DIR_NEG = 1'b0;
endpackage

// File: rtl/pong_if.sv
// pong_if: controller-facing signals; master is the renderer/paddle side, slave is the controller.
interface pong_if;
    import pong_pkg::*;
    logic vsync;
    logic [31:0] lpaddle;
    logic [31:0] rpaddle;
    logic start;
    logic [4:0] ball_x;
    logic [4:0] ball_y;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic game_over;
    logic frame_tick;
    modport master(output vsync, lpaddle, rpaddle, start,
                   input ball_x, ball_y, score_l, score_r, game_over, frame_tick);
    modport slave(input vsync, lpaddle, rpaddle, start,
                  output ball_x, ball_y, score_l, score_r, game_over, frame_tick);
endinterface

// File: rtl/pong_frame_tick.sv
// pong_frame_tick: registers vsync and emits a one-cycle pulse on each inactive->active edge.
module pong_frame_tick
    import pong_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic vsync,
    output logic frame_tick
);
    localparam logic ACT = ACTIVE_LOW ? 1'b0 : 1'b1;
    logic vs_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vs_q <= ~ACT;
            frame_tick <= 1'b0;
        end else begin
            vs_q <= vsync;
            frame_tick <= (vsync == ACT) && (vs_q != ACT);
        end
    end
endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: ball/score sequencer stepping on frame ticks through serve, play, miss and game-over.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned FRAMES_PER_STEP = 4,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned WIN_SCORE = 9,
    parameter bit VSYNC_ACTIVE_LOW = 1'b1
) (
    input logic clk,
    input logic reset,
    pong_if.slave bus
);
    state_t state_q, state_d;
    logic [4:0] x_q, x_d, y_q, y_d, ny;
    logic dx_q, dx_d, dy_q, dy_d, ndy, tick;
    logic [3:0] sl_q, sl_d, sr_q, sr_d;
    logic [7:0] step_q, step_d, serve_q, serve_d;

    pong_frame_tick #(.ACTIVE_LOW(VSYNC_ACTIVE_LOW)) u_tick (
        .clk(clk), .reset(reset), .vsync(bus.vsync), .frame_tick(tick)
    );

    // wall bounce is resolved first so the paddle test sees the post-bounce row
    assign ndy = ((y_q == 5'd0 && dy_q == DIR_NEG) || (y_q == 5'd31 && dy_q == DIR_POS)) ? ~dy_q : dy_q;
    assign ny = ndy ? y_q + 5'd1 : y_q - 5'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SERVE;
            x_q <= CENTER;
            y_q <= CENTER;
            dx_q <= DIR_POS;
            dy_q <= DIR_POS;
            sl_q <= 4'd0;
            sr_q <= 4'd0;
            step_q <= 8'd0;
            serve_q <= 8'd0;
        end else begin
            state_q <= state_d;
            x_q <= x_d;
            y_q <= y_d;
            dx_q <= dx_d;
            dy_q <= dy_d;
            sl_q <= sl_d;
            sr_q <= sr_d;
            step_q <= step_d;
            serve_q <= serve_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d = x_q;
        y_d = y_q;
        dx_d = dx_q;
        dy_d = dy_q;
        sl_d = sl_q;
        sr_d = sr_q;
        step_d = step_q;
        serve_d = serve_q;
        if (state_q == GAMEOVER) begin
            if (bus.start) begin
                state_d = SERVE;
                x_d = CENTER;
                y_d = CENTER;
                dx_d = DIR_POS;
                dy_d = DIR_POS;
                sl_d = 4'd0;
                sr_d = 4'd0;
                step_d = 8'd0;
                serve_d = 8'd0;
            end
        end else if (tick) begin
            case (state_q)
                SERVE: begin
                    x_d = CENTER;
                    y_d = CENTER;
                    serve_d = serve_q + 8'd1;
                    if (serve_q == 8'(SERVE_FRAMES - 1)) begin
                        serve_d = 8'd0;
                        step_d = 8'd0;
                        state_d = PLAY;
                    end
                end
                PLAY: begin
                    step_d = step_q + 8'd1;
                    if (step_q == 8'(FRAMES_PER_STEP - 1)) begin
                        step_d = 8'd0;
                        y_d = ny;
                        dy_d = ndy;
                        if (dx_q == DIR_POS && x_q == LCOL - 5'd1) begin
                            dx_d = bus.lpaddle[ny] ? DIR_NEG : dx_q;
                            x_d = bus.lpaddle[ny] ? LCOL - 5'd2 : LCOL;
                            sr_d = bus.lpaddle[ny] ? sr_q : sr_q + 4'd1;
                            state_d = bus.lpaddle[ny] ? PLAY : MISS;
                        end else if (dx_q == DIR_NEG && x_q == RCOL + 5'd1) begin
                            dx_d = bus.rpaddle[ny] ? DIR_POS : dx_q;
                            x_d = bus.rpaddle[ny] ? RCOL + 5'd2 : RCOL;
                            sl_d = bus.rpaddle[ny] ? sl_q : sl_q + 4'd1;
                            state_d = bus.rpaddle[ny] ? PLAY : MISS;
                        end else begin
                            x_d = dx_q ? x_q + 5'd1 : x_q - 5'd1;
                        end
                    end
                end
                MISS: begin
                    serve_d = serve_q + 8'd1;
                    if (serve_q == 8'(SERVE_FRAMES - 1)) begin
                        serve_d = 8'd0;
                        // dx is left as-is: it already points at the player who conceded
                        if (sl_q == 4'(WIN_SCORE) || sr_q == 4'(WIN_SCORE)) begin
                            state_d = GAMEOVER;
                        end else begin
                            state_d = SERVE;
                            x_d = CENTER;
                            y_d = CENTER;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ball_x = x_q;
    assign bus.ball_y = y_q;
    assign bus.score_l = sl_q;
    assign bus.score_r = sr_q;
    assign bus.game_over = (state_q == GAMEOVER);
    assign bus.frame_tick = tick;
endmodule
